// File: rtl/reg_dump_pkg.sv
// Shared types and default sizing for the register dump engine.
// Imported by reg_dump and anything that wants its state names.
package reg_dump_pkg;

  localparam int NUM_REGS_DEF = 32;
  localparam int ADDR_W_DEF   = 5;
  localparam int DATA_W_DEF   = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_READ,
    S_SEND,
    S_DONE
  } state_t;

endpackage

// File: rtl/reg_dump.sv
// Streams a range of architectural registers out over valid/ready
// while holding core writeback off the register file.
module reg_dump
  import reg_dump_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic              stall_core,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] TOP_IDX =
    ADDR_W'(NUM_REGS - 1);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] cur;
  logic [ADDR_W-1:0] end_idx;
  logic [ADDR_W-1:0] cur_inc;
  logic              xfer;
  logic              last_word;

  assign xfer      = (state == S_SEND) && out_ready;
  assign last_word = (cur == end_idx);

  // Index arithmetic wraps at NUM_REGS, not at 2**ADDR_W.
  assign cur_inc = (cur == TOP_IDX) ? '0 : cur + 1'b1;

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (start) state_nxt = S_HOLD;
      S_HOLD: state_nxt = S_READ;
      S_READ: state_nxt = S_SEND;
      S_SEND: begin
        if (xfer) begin
          state_nxt = last_word ? S_DONE : S_READ;
        end
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cur      <= '0;
      end_idx  <= '0;
      out_addr <= '0;
      out_data <= '0;
    end else begin
      state <= state_nxt;
      if (!abort) begin
        if (state == S_IDLE && start) begin
          cur     <= first_addr;
          end_idx <= last_addr;
        end
        if (state == S_READ) begin
          out_addr <= cur;
          out_data <= rf_data;
        end
        if (xfer && !last_word) begin
          cur <= cur_inc;
        end
      end
    end
  end

  assign rf_addr    = cur;
  assign out_valid  = (state == S_SEND);
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);
  assign stall_core = (state == S_HOLD) ||
                      (state == S_READ) ||
                      (state == S_SEND);

endmodule
